// File: rtl/power_uart_framer.sv
// power_uart_framer: captures each Goertzel power result and sends it to a byte-wide UART
// as a frame: SYNC, sequence number, payload bytes MSB-first, and an optional checksum.
// A result that arrives mid-frame is held in a one-deep pending buffer. A further result
// is dropped and counted.
//
// Optional feature: define FRAMER_CHECKSUM_EN to append a mod-256 checksum byte. The
// checksum covers seq and the payload, not SYNC.
//
// Ports:
//   clock, reset_n     - single clock; synchronous active-low reset
//   ready, power       - result strobe and the result it marks
//   send, data, done   - UART byte handshake (send pulse, byte, done pulse)
//   busy               - a frame is in progress
//   frame_sent         - one-cycle pulse after the last byte completes
//   overrun_count      - count of dropped results, saturating at 255
module power_uart_framer #(
  parameter int unsigned POWER_W = 64,
  parameter int unsigned BYTES   = 8,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ready,
  input  logic [POWER_W-1:0] power,
  output logic               send,
  output logic [7:0]         data,
  input  logic               done,
  output logic               busy,
  output logic               frame_sent,
  output logic [7:0]         overrun_count
);

  localparam int unsigned PayW = 8 * BYTES;
`ifdef FRAMER_CHECKSUM_EN
  localparam int unsigned NumBytes = BYTES + 3;
  // idx value at which the checksum byte is staged (all summed bytes already staged)
  localparam logic [3:0] CsumPrepIdx = 4'(BYTES + 1);
`else
  localparam int unsigned NumBytes = BYTES + 2;
`endif
  localparam logic [3:0] LastIdx = 4'(NumBytes - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StWait} state_e;

  state_e          state_q, state_d;
  logic [PayW-1:0] shift_q, shift_d;
  logic [PayW-1:0] pend_data_q, pend_data_d;
  logic            pend_valid_q, pend_valid_d;
  logic [7:0]      seq_q, seq_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            adv_q, adv_d;
  logic            frame_sent_q, frame_sent_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [PayW-1:0] payload;

`ifdef FRAMER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign payload = power[POWER_W-1 -: PayW];

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    seq_d        = seq_q;
    idx_d        = idx_q;
    data_d       = data_q;
    adv_d        = 1'b0;
    frame_sent_d = 1'b0;
    ovr_d        = ovr_q;

    // Results arriving while busy (including on the final done) go to the pending slot.
    if (ready && (state_q != StIdle)) begin
      if (!pend_valid_q) begin
        pend_data_d  = payload;
        pend_valid_d = 1'b1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (ready) begin
          shift_d = payload;
          state_d = StLoad;
        end else if (pend_valid_q) begin
          shift_d      = pend_data_q;
          pend_valid_d = 1'b0;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        idx_d   = 4'd0;
        data_d  = SYNC;
        state_d = StSend;
      end
      StSend: state_d = StWait;
      StWait: begin
        // adv_q marks the cycle after an accepted done: the next byte is staged, so
        // move to SEND and ignore done here.
        if (adv_q) begin
          state_d = StSend;
        end else if (done) begin
          if (idx_q == LastIdx) begin
            frame_sent_d = 1'b1;
            seq_d        = seq_q + 8'd1;
            state_d      = StIdle;
          end else begin
            idx_d = idx_q + 4'd1;
            adv_d = 1'b1;
            if (idx_q == 4'd0) begin
              data_d = seq_q;
`ifdef FRAMER_CHECKSUM_EN
            end else if (idx_q == CsumPrepIdx) begin
              data_d = csum_q;
`endif
            end else begin
              data_d  = shift_q[PayW-1 -: 8];
              shift_d = shift_q << 8;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      seq_q        <= 8'd0;
      idx_q        <= 4'd0;
      data_q       <= 8'd0;
      adv_q        <= 1'b0;
      frame_sent_q <= 1'b0;
      ovr_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      seq_q        <= seq_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      adv_q        <= adv_d;
      frame_sent_q <= frame_sent_d;
      ovr_q        <= ovr_d;
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  // Sum every staged seq/payload byte; the checksum byte itself is staged at CsumPrepIdx.
  always_comb begin
    csum_d = csum_q;
    if (state_q == StLoad) begin
      csum_d = 8'd0;
    end else if ((state_q == StWait) && !adv_q && done && (idx_q < CsumPrepIdx)) begin
      csum_d = csum_q + data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      csum_q <= 8'd0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign send          = (state_q == StSend);
  assign busy          = (state_q != StIdle);
  assign data          = data_q;
  assign frame_sent    = frame_sent_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_power_uart_framer.sv
// Directed bench for power_uart_framer. A UART model answers each send with done three
// cycles later. A monitor logs sent bytes and the cycles of send/done/frame_sent.
module tb_power_uart_framer;

`ifdef FRAMER_CHECKSUM_EN
  localparam int FrameLen = 11;
`else
  localparam int FrameLen = 10;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] power = '0;
  logic        send;
  logic [7:0]  data;
  logic        done;
  logic        tb_done = 1'b0;
  logic        uart_done = 1'b0;
  logic        busy;
  logic        frame_sent;
  logic [7:0]  overrun_count;

  int tests = 0;
  int fails = 0;

  assign done = tb_done | uart_done;

  always #5 clock = ~clock;

  power_uart_framer #(
    .POWER_W(64),
    .BYTES  (8),
    .SYNC   (8'hA5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready        (ready),
    .power        (power),
    .send         (send),
    .data         (data),
    .done         (done),
    .busy         (busy),
    .frame_sent   (frame_sent),
    .overrun_count(overrun_count)
  );

  // Monitor and UART model, sampling 1 time unit after each rising edge.
  int         cyc = 0;
  bit         uart_auto = 1'b1;
  int         ucnt = 0;
  logic [7:0] bytes_q[$];
  int         send_cyc_q[$];
  int         done_cyc_q[$];
  int         fs_count = 0;
  int         fs_cyc = 0;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (send) begin
        bytes_q.push_back(data);
        send_cyc_q.push_back(cyc);
      end
      if (frame_sent) begin
        fs_count++;
        fs_cyc = cyc;
      end
      uart_done = 1'b0;
      if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin
          uart_done = 1'b1;
          done_cyc_q.push_back(cyc);
        end
      end
      if (send && uart_auto) ucnt = 3;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ready   = 1'b0;
    tb_done = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    bytes_q.delete();
    send_cyc_q.delete();
    done_cyc_q.delete();
    fs_count  = 0;
    uart_auto = 1'b1;
  endtask

  task automatic pulse_ready(input logic [63:0] p);
    power = p;
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while ((fs_count < n) && (k < budget)) begin
      tick();
      k++;
    end
    check("frame_sent_timeout", 64'(fs_count >= n), 64'd1);
  endtask

  logic [7:0] exp_frame[11] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                                8'hCD, 8'hEF, 8'hC0};

  initial begin
    int k;
    int base;

    // Reset values
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_send", 64'(send), 64'd0);
    check("rst_data", 64'(data), 64'h00);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_sent", 64'(frame_sent), 64'd0);
    check("rst_overrun", 64'(overrun_count), 64'd0);

    // Single frame with start latency and inter-byte timing
    do_reset();
    power = 64'h0123456789ABCDEF;
    ready = 1'b1;
    tick();
    check("start_busy_t1", 64'(busy), 64'd1);
    check("start_nosend_t1", 64'(send), 64'd0);
    ready = 1'b0;
    tick();
    check("start_send_t2", 64'(send), 64'd1);
    check("start_data_t2", 64'(data), 64'hA5);
    wait_frames(1, 300);
    check("busy_after_frame", 64'(busy), 64'd0);
    check("f1_len", 64'(bytes_q.size()), 64'(FrameLen));
    for (int i = 0; i < FrameLen; i++) begin
      if (i < bytes_q.size()) check($sformatf("f1_byte%0d", i), 64'(bytes_q[i]), 64'(exp_frame[i]));
    end
    for (int i = 0; i < FrameLen - 1; i++) begin
      if ((i + 1 < send_cyc_q.size()) && (i < done_cyc_q.size()))
        check($sformatf("gap_done_send%0d", i), 64'(send_cyc_q[i+1] - done_cyc_q[i]), 64'd2);
    end
    if (done_cyc_q.size() >= FrameLen)
      check("fs_after_done", 64'(fs_cyc - done_cyc_q[FrameLen-1]), 64'd1);
    for (int i = 0; i < 20; i++) tick();
    check("f1_fs_count", 64'(fs_count), 64'd1);
    check("f1_no_extra_bytes", 64'(bytes_q.size()), 64'(FrameLen));

    // Three results during one frame: one pending, one dropped
    do_reset();
    pulse_ready(64'h0123456789ABCDEF);
    for (int i = 0; i < 3; i++) tick();
    pulse_ready(64'h1111111111111111);
    for (int i = 0; i < 3; i++) tick();
    pulse_ready(64'h2222222222222222);
    tick();
    check("overrun_one", 64'(overrun_count), 64'd1);
    wait_frames(2, 600);
    check("pend_len", 64'(bytes_q.size()), 64'(2 * FrameLen));
    if (bytes_q.size() >= 2 * FrameLen) begin
      check("pend_sync", 64'(bytes_q[FrameLen]), 64'hA5);
      check("pend_seq", 64'(bytes_q[FrameLen+1]), 64'h01);
      check("pend_pay0", 64'(bytes_q[FrameLen+2]), 64'h11);
`ifdef FRAMER_CHECKSUM_EN
      check("pend_csum", 64'(bytes_q[2*FrameLen-1]), 64'h89);
`endif
    end
    if ((send_cyc_q.size() > FrameLen) && (done_cyc_q.size() >= FrameLen))
      check("pend_restart", 64'(send_cyc_q[FrameLen] - done_cyc_q[FrameLen-1]), 64'd3);
    for (int i = 0; i < 60; i++) tick();
    check("dropped_not_sent", 64'(fs_count), 64'd2);
    check("overrun_kept", 64'(overrun_count), 64'd1);

    // Sequence wrap over 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) begin
      bytes_q.delete();
      pulse_ready(64'h0123456789ABCDEF);
      wait_frames(f + 1, 300);
      if ((f == 255) && (bytes_q.size() > 1)) check("wrap_seq_ff", 64'(bytes_q[1]), 64'hFF);
      if ((f == 256) && (bytes_q.size() > 1)) check("wrap_seq_00", 64'(bytes_q[1]), 64'h00);
    end

    // Reset mid-frame with a pending result
    do_reset();
    pulse_ready(64'h0123456789ABCDEF);
    tick();
    pulse_ready(64'h3333333333333333);
    k = 0;
    while ((bytes_q.size() < 4) && (k < 200)) begin
      tick();
      k++;
    end
    check("midrst_reached_b4", 64'(bytes_q.size()), 64'd4);
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_send", 64'(send), 64'd0);
    check("midrst_data", 64'(data), 64'h00);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_frame_sent", 64'(frame_sent), 64'd0);
    check("midrst_overrun", 64'(overrun_count), 64'd0);
    reset_n = 1'b1;
    base = bytes_q.size();
    for (int i = 0; i < 60; i++) tick();
    check("midrst_no_send", 64'(bytes_q.size()), 64'(base));
    check("midrst_no_fs", 64'(fs_count), 64'd0);
    bytes_q.delete();
    pulse_ready(64'h4455667788990011);
    wait_frames(1, 300);
    check("midrst_len", 64'(bytes_q.size()), 64'(FrameLen));
    if (bytes_q.size() > 2) begin
      check("midrst_seq", 64'(bytes_q[1]), 64'h00);
      check("midrst_pay0", 64'(bytes_q[2]), 64'h44);
    end
    for (int i = 0; i < 60; i++) tick();
    check("midrst_pend_gone", 64'(fs_count), 64'd1);

    // Stray done in IDLE and done coincident with send
    do_reset();
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    tick();
    check("stray_idle_busy", 64'(busy), 64'd0);
    check("stray_idle_nosend", 64'(bytes_q.size()), 64'd0);
    uart_auto = 1'b0;
    pulse_ready(64'h0123456789ABCDEF);
    tick();
    check("stray_send", 64'(send), 64'd1);
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("stray_still_waiting", 64'(busy), 64'd1);
    check("stray_one_byte", 64'(bytes_q.size()), 64'd1);
    uart_auto = 1'b1;
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    wait_frames(1, 300);
    check("stray_len", 64'(bytes_q.size()), 64'(FrameLen));
    if (bytes_q.size() >= FrameLen) begin
      check("stray_seq", 64'(bytes_q[1]), 64'h00);
      check("stray_last", 64'(bytes_q[FrameLen-1]), 64'(exp_frame[FrameLen-1]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
